// File: rtl/int_response_unit.sv
// Interrupt responder: pushes return PC/source on take, pops on ERET, redirects fetch and owns IntEnable.
// Latency: 1 cycle from the qualifying WB cycle to the REDIRECT cycle; a bad ERET raises eret_err 1 cycle later.
// No backpressure: a request that cannot be taken (IE=0 or stack full) simply stays pending at the controller.
module int_response_unit #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        IntRequest,
    input  logic [1:0]  IntNum,
    input  logic        wb_valid,
    input  logic        ERET,
    input  logic [31:0] WB_NOINT_NextPC,
    input  logic        sti,
    input  logic        cli,
    output logic        IntEnable,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        int_taken,
    output logic        eret_done,
    output logic [1:0]  eret_num,
    output logic        eret_err,
    output logic        stack_full,
    output logic [3:0]  cur_depth
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          SLOTS   = 1 << AW;
    localparam logic [3:0]  DEPTH_W = 4'(DEPTH);

    typedef enum logic {IDLE, REDIRECT} state_t;

    state_t          state, state_nxt;
    logic [3:0]      sp;
    logic [AW-1:0]   sp_idx, pop_idx;
    logic [1:0]      stk_num [0:SLOTS-1];
    logic [31:0]     stk_pc  [0:SLOTS-1];
    logic            idle, take, pop, eret_empty;

    assign idle       = (state == IDLE);
    assign sp_idx     = sp[AW-1:0];
    assign pop_idx    = sp_idx - AW'(1);
    assign take       = idle & IntRequest & IntEnable & wb_valid & ~ERET & (sp < DEPTH_W);
    assign pop        = idle & ERET & wb_valid & (sp != 4'd0);
    assign eret_empty = idle & ERET & wb_valid & (sp == 4'd0);

    assign redirect_valid = (state == REDIRECT);
    assign flush          = (state == REDIRECT);
    assign cur_depth      = sp;
    assign stack_full     = (sp == DEPTH_W);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (take | pop) state_nxt = REDIRECT;
            REDIRECT: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sp          <= 4'd0;
            IntEnable   <= 1'b1;
            redirect_pc <= 32'd0;
            eret_num    <= 2'd0;
            int_taken   <= 1'b0;
            eret_done   <= 1'b0;
            eret_err    <= 1'b0;
        end else begin
            int_taken <= take;
            eret_done <= pop;
            eret_err  <= eret_empty;
            // take and pop are mutually exclusive (take requires ~ERET)
            if (take) begin
                sp          <= sp + 4'd1;
                redirect_pc <= VEC_BASE + 32'(IntNum) * VEC_STRIDE;
                IntEnable   <= 1'b0;
            end else if (pop) begin
                sp          <= sp - 4'd1;
                redirect_pc <= stk_pc[pop_idx];
                eret_num    <= stk_num[pop_idx];
                IntEnable   <= 1'b1;
            end else if (idle & cli) begin
                IntEnable <= 1'b0;
            end else if (idle & sti) begin
                IntEnable <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            stk_num[sp_idx] <= IntNum;
            stk_pc[sp_idx]  <= WB_NOINT_NextPC;
        end
    end

endmodule

// File: doc/int_response_unit.md
Name: int_response_unit

Overview:
- CPU-side responder to the interrupt controller.
- Consumes the controller's IntRequest/IntNum at the write-back boundary and saves the return PC plus the source number on a nesting stack.
- Redirects fetch to the per-source handler vector, flushes the pipeline, and owns the global IntEnable bit fed back to the controller.
- On ERET it pops the stack, redirects to the saved PC, re-enables interrupts and reports which source completed.

Parameters:
DEPTH, 4, nesting stack entries (one per interrupt source); legal range 1..8.
VEC_BASE, 32'h0000_0100, handler vector for source 0.
VEC_STRIDE, 32'h0000_0020, byte distance between consecutive source vectors.

Ports:
clk  in  1  system clock, rising edge.
clr  in  1  asynchronous active-high reset.
IntRequest  in  1  pending unmasked interrupt from the controller.
IntNum  in  2  number of the requesting source.
wb_valid  in  1  an instruction retires in WB this cycle.
ERET  in  1  the retiring WB instruction is ERET; only meaningful with wb_valid.
WB_NOINT_NextPC  in  32  sequential next PC of the retiring instruction.
sti  in  1  software set-IE strobe.
cli  in  1  software clear-IE strobe.
IntEnable  out  1  global interrupt enable, feeds the controller.
redirect_valid  out  1  fetch redirect strobe.
redirect_pc  out  32  fetch redirect target.
flush  out  1  kill IF..MEM; asserted together with redirect_valid.
int_taken  out  1  one-cycle pulse, interrupt accepted.
eret_done  out  1  one-cycle pulse, ERET popped a stack entry.
eret_num  out  2  source number of the popped entry; valid with eret_done.
eret_err  out  1  one-cycle pulse, ERET executed with an empty stack.
stack_full  out  1  stack pointer equals DEPTH.
cur_depth  out  4  current nesting depth, 0..DEPTH.

Behaviour:
- Reset (async, clr=1):
  - state=IDLE, sp=0, IntEnable=1.
  - redirect_valid, flush, int_taken, eret_done and eret_err are 0; redirect_pc=0; eret_num=0.
  - Stack contents are don't-care.
  - Asserting clr mid-redirect drops the redirect immediately.
- States:
  - IDLE: decisions are evaluated.
  - REDIRECT: lasts exactly one cycle; redirect_valid=flush=1 and all inputs except clr are ignored. Always returns to IDLE.
- Accept (evaluated in IDLE only): take = IntRequest & IntEnable & wb_valid & ~ERET & (sp<DEPTH).
- On take (registered, latency 1):
  - push {IntNum, WB_NOINT_NextPC} at stack[sp]; sp<=sp+1; IntEnable<=0.
  - redirect_pc<=VEC_BASE+IntNum*VEC_STRIDE, with a 32-bit wrap-around add.
  - int_taken pulses in the REDIRECT cycle.
- ERET pop: ERET & wb_valid & (sp>0) in IDLE.
  - sp<=sp-1; redirect_pc<=saved pc; eret_num<=saved num; IntEnable<=1.
  - eret_done pulses in the REDIRECT cycle.
- ERET with sp==0:
  - eret_err pulses for one cycle.
  - No redirect, no flush, IntEnable unchanged, state stays IDLE.
- ERET and IntRequest in the same cycle: ERET wins, and the interrupt is re-evaluated after REDIRECT.
- Stack full (sp==DEPTH): requests are not accepted; no state change, IntRequest simply remains pending. stack_full=1.
- IntEnable update priority (highest first): entry clear, ERET set, cli, sti. sti and cli are honoured in IDLE only.
- Nesting: a handler executes sti to allow a further request. Pushes and pops are strictly LIFO.
- Output timing: cur_depth=sp and stack_full are combinational from registers. All pulses are registered and exactly one cycle wide.

Test Plan:
- Reset, then IntRequest=1, IntNum=2, wb_valid=1, NextPC=32'h0000_0040 -> next cycle: redirect_valid=flush=int_taken=1, redirect_pc=32'h0000_0140, IntEnable=0, cur_depth=1.
- Same state, then ERET=1, wb_valid=1 -> next cycle: redirect_pc=32'h0000_0040, eret_done=1, eret_num=2, IntEnable=1, cur_depth=0.
- Nesting:
  - Take source 1 with NextPC=32'h10; sti; take source 3 with NextPC=32'h200 -> redirect_pc=32'h0000_0160, depth=2.
  - ERET -> redirect_pc=32'h200, eret_num=3.
  - ERET -> redirect_pc=32'h10, eret_num=1.
- DEPTH=4 with sti after each take:
  - Four takes -> stack_full=1.
  - A fifth IntRequest is held high -> no redirect and no int_taken; after one ERET it is accepted on the next wb_valid.
- ERET with empty stack -> eret_err pulse only, no redirect_valid, IntEnable stays 1.
- Simultaneous cases:
  - ERET and IntRequest in one cycle -> pop first, REDIRECT cycle ignores the request, the interrupt is taken the following qualifying cycle.
  - sti and cli together -> IntEnable=0.
  - clr asserted during REDIRECT -> outputs 0 immediately.
